// File: rtl/lane_accumulator_pkg.sv
// lane_accumulator_pkg: FSM states and sizing helpers shared by the lane accumulator.
package lane_accumulator_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DUMP} state_t;
  function automatic int cnt_width(input int len);
    return len > 1 ? $clog2(len) : 1;
  endfunction
endpackage

// File: rtl/sat_add.sv
// sat_add: two's complement adder that clamps to the W-bit signed range and flags the clamp.
module sat_add #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         ovf
);
  localparam logic [W-1:0] MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
  logic [W:0] sum;
  assign sum = {a[W-1], a} + {b[W-1], b};
  assign ovf = sum[W] ^ sum[W-1];
  assign y   = ovf ? (sum[W] ? MIN : MAX) : sum[W-1:0];
endmodule

// File: rtl/lane_accumulator.sv
// lane_accumulator: integrate-and-dump of ACC_LEN samples per lane with saturating sums.
module lane_accumulator
  import lane_accumulator_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int ACC_LEN    = 16,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en_n,
  input  logic                        clr,
  input  logic                        validIn,
  input  logic [DATA_WIDTH*DEPTH-1:0] dataIn,
  output logic [ACC_WIDTH*DEPTH-1:0]  dataOut,
  output logic                        validOut,
  output logic [DEPTH-1:0]            ovf
);
  localparam int CW = cnt_width(ACC_LEN);
  state_t                             state;
  logic [CW-1:0]                      count;
  logic [DEPTH-1:0][ACC_WIDTH-1:0]    acc, sum;
  logic [DEPTH-1:0]                   sat, lane_ovf;
  logic                               last;
  assign last = count == CW'(ACC_LEN - 1);
  for (genvar i = 0; i < DEPTH; i++) begin : g_lane
    logic signed [DATA_WIDTH-1:0] s;
    assign s = dataIn[DATA_WIDTH*i +: DATA_WIDTH];
    sat_add #(.W(ACC_WIDTH)) u_add (
      .a(acc[i]), .b(ACC_WIDTH'(s)), .y(sum[i]), .ovf(lane_ovf[i])
    );
  end
  // accumulators are zeroed at completion, so a sample taken in DUMP starts the next window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      acc      <= '0;
      sat      <= '0;
      dataOut  <= '0;
      ovf      <= '0;
      validOut <= 1'b0;
    end else begin
      validOut <= 1'b0;
      if (!en_n) begin
        if (clr) begin
          state <= IDLE;
          count <= '0;
          acc   <= '0;
          sat   <= '0;
        end else if (validIn) begin
          if (last) begin
            dataOut  <= sum;
            ovf      <= sat | lane_ovf;
            validOut <= 1'b1;
            acc      <= '0;
            sat      <= '0;
            count    <= '0;
            state    <= DUMP;
          end else begin
            acc   <= sum;
            sat   <= sat | lane_ovf;
            count <= count + 1'b1;
            state <= ACCUM;
          end
        end else if (state == DUMP) begin
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_lane_accumulator.sv
// tb_lane_accumulator: three instances (ACC_LEN 4, 2, 1) checked against a window-sum model.
module tb_lane_accumulator;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_n = 1'b0;
  logic        clr = 1'b0;
  logic        validIn = 1'b0;
  logic [63:0] dataIn = '0;
  logic [63:0] dout [3];
  logic        vout [3];
  logic [1:0]  oflg [3];
  int          n_cmp = 0;
  int          n_err = 0;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;
  int          lens [3] = '{4, 2, 1};
  longint      acc [3][2];
  bit          sat [3][2];
  int          cnt [3];
  logic [63:0] e_dout [3];
  logic [1:0]  e_ovf [3];
  logic        e_v [3];
  int          pulses, first_p, last_p;

  always #5 clk = ~clk;

  lane_accumulator #(.DATA_WIDTH(32), .DEPTH(2), .ACC_LEN(4), .ACC_WIDTH(32)) u_l4 (
    .clk(clk), .rst(rst), .en_n(en_n), .clr(clr), .validIn(validIn), .dataIn(dataIn),
    .dataOut(dout[0]), .validOut(vout[0]), .ovf(oflg[0]));
  lane_accumulator #(.DATA_WIDTH(32), .DEPTH(2), .ACC_LEN(2), .ACC_WIDTH(32)) u_l2 (
    .clk(clk), .rst(rst), .en_n(en_n), .clr(clr), .validIn(validIn), .dataIn(dataIn),
    .dataOut(dout[1]), .validOut(vout[1]), .ovf(oflg[1]));
  lane_accumulator #(.DATA_WIDTH(32), .DEPTH(2), .ACC_LEN(1), .ACC_WIDTH(32)) u_l1 (
    .clk(clk), .rst(rst), .en_n(en_n), .clr(clr), .validIn(validIn), .dataIn(dataIn),
    .dataOut(dout[2]), .validOut(vout[2]), .ovf(oflg[2]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s.len%0d.validOut", tag, lens[k]), 64'(vout[k]), 64'(e_v[k]));
      chk($sformatf("%s.len%0d.dataOut", tag, lens[k]), dout[k], e_dout[k]);
      chk($sformatf("%s.len%0d.ovf", tag, lens[k]), 64'(oflg[k]), 64'(e_ovf[k]));
    end
  endtask

  function automatic void clear_window(input int k);
    cnt[k] = 0;
    for (int l = 0; l < 2; l++) begin
      acc[k][l] = 0;
      sat[k][l] = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      clear_window(k);
      e_dout[k] = '0;
      e_ovf[k]  = '0;
      e_v[k]    = 1'b0;
    end
  endfunction

  // One clock of the spec's behaviour: enabled accepted samples are summed and clamped per lane.
  function automatic void model_edge(input logic e, input logic c, input logic v, input logic [63:0] d);
    for (int k = 0; k < 3; k++) begin
      e_v[k] = 1'b0;
      if (e) continue;
      if (c) begin
        clear_window(k);
      end else if (v) begin
        for (int l = 0; l < 2; l++) begin
          logic [31:0] w;
          longint s;
          w = d[32*l +: 32];
          s = acc[k][l] + longint'($signed(w));
          if (s > SMAX) begin s = SMAX; sat[k][l] = 1'b1; end
          if (s < SMIN) begin s = SMIN; sat[k][l] = 1'b1; end
          acc[k][l] = s;
        end
        cnt[k]++;
        if (cnt[k] == lens[k]) begin
          e_dout[k] = {32'(acc[k][1]), 32'(acc[k][0])};
          e_ovf[k]  = {sat[k][1], sat[k][0]};
          e_v[k]    = 1'b1;
          clear_window(k);
        end
      end
    end
  endfunction

  task automatic step(input string tag, input logic e, input logic c, input logic v, input logic [63:0] d);
    en_n = e; clr = c; validIn = v; dataIn = d;
    @(posedge clk);
    model_edge(e, c, v, d);
    #1;
    check_all(tag);
  endtask

  task automatic pulse_reset(input string tag);
    en_n = 1'b0; clr = 1'b0; validIn = 1'b0; dataIn = '0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1 rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #12 rst = 1'b0;
    @(posedge clk); #1;
    check_all("reset");

    // basic sums
    for (int i = 1; i <= 4; i++) step("basic", 0, 0, 1, {32'hFFFFFFFF, 32'(i)});
    chk("basic_sum_len4", dout[0], 64'hFFFFFFFC_0000000A);
    chk("basic_ovf_len4", 64'(oflg[0]), 64'h0);
    step("basic_idle", 0, 0, 0, '0);

    // saturation
    for (int i = 0; i < 2; i++) step("sat", 0, 0, 1, 64'h80000000_7FFFFFFF);
    chk("sat_sum_len2", dout[1], 64'h80000000_7FFFFFFF);
    chk("sat_ovf_len2", 64'(oflg[1]), 64'h3);
    for (int i = 0; i < 2; i++) step("sat", 0, 0, 1, 64'h80000000_7FFFFFFF);
    for (int i = 0; i < 2; i++) step("sat_zero", 0, 0, 1, '0);
    chk("zero_ovf_len2", 64'(oflg[1]), 64'h0);

    // continuous stream
    step("stream_clr", 0, 1, 0, '0);
    pulses = 0; first_p = -1; last_p = -1;
    for (int i = 0; i < 12; i++) begin
      step("stream", 0, 0, 1, {32'd5, 32'd5});
      if (vout[0]) begin
        pulses++;
        if (first_p < 0) first_p = i;
        last_p = i;
      end
    end
    chk("stream_pulses", 64'(pulses), 64'd3);
    chk("stream_first", 64'(first_p), 64'd3);
    chk("stream_last", 64'(last_p), 64'd11);
    chk("stream_sum", dout[0], {32'd20, 32'd20});

    // gaps and enable
    step("gap_clr", 0, 1, 0, '0);
    for (int i = 0; i < 40; i++)
      step("gap", 1'($urandom_range(0, 2) == 0), 0, 1'($urandom_range(0, 1)),
           {32'($urandom_range(0, 200)) - 32'd100, 32'($urandom_range(0, 200)) - 32'd100});

    // clear mid-window
    step("clr_pre", 0, 1, 0, '0);
    for (int i = 0; i < 3; i++) step("clr_part", 0, 0, 1, {32'd9, 32'd9});
    step("clr", 0, 1, 1, {32'd9, 32'd9});
    for (int i = 0; i < 4; i++) step("clr_new", 0, 0, 1, {32'd2, 32'd2});
    chk("clr_sum_len4", dout[0], {32'd8, 32'd8});

    // reset mid-window
    for (int i = 0; i < 2; i++) step("rst_part", 0, 0, 1, {32'd4, 32'd4});
    pulse_reset("rst_mid");
    for (int i = 0; i < 4; i++) step("rst_new", 0, 0, 1, {32'd3, 32'd3});
    chk("rst_sum_len4", dout[0], {32'd12, 32'd12});

    // single-sample windows
    step("len1_a", 0, 0, 1, {32'd7, 32'd7});
    chk("len1_first", dout[2], {32'd7, 32'd7});
    step("len1_b", 0, 0, 1, {32'hFFFFFFF9, 32'hFFFFFFF9});
    chk("len1_second", dout[2], {32'hFFFFFFF9, 32'hFFFFFFF9});

    // randomized mix, including near-limit values
    for (int i = 0; i < 300; i++) begin
      logic [63:0] d;
      d = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) d = {32'h80000000 + 32'($urandom_range(0, 15)), 32'h7FFFFFF0 + 32'($urandom_range(0, 15))};
      step("rand", 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0), d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
